// File: rtl/riscv_mul_ctrl.sv
// Sequencer between execute and the iterative Booth multiplier: latch, drive, drain, hold result.
// Defining RISCV_MUL_CTRL_REUSE_EN adds a last-result tag that short-circuits repeated requests.
module riscv_mul_ctrl #(
    parameter int unsigned TIMEOUT = 96,
    parameter int unsigned XLEN    = 64
) (
    input  logic            i_riscv_mul_clk,
    input  logic            i_riscv_mul_rst,
    input  logic            i_riscv_mulctl_req_valid,
    input  logic [3:0]      i_riscv_mulctl_mulctrl,
    input  logic [XLEN-1:0] i_riscv_mulctl_rs1data,
    input  logic [XLEN-1:0] i_riscv_mulctl_rs2data,
    input  logic [4:0]      i_riscv_mulctl_rdaddr,
    input  logic            i_riscv_mulctl_flush,
    input  logic            i_riscv_mulctl_ack,
    output logic            o_riscv_mulctl_stall,
    output logic            o_riscv_mulctl_result_valid,
    output logic [XLEN-1:0] o_riscv_mulctl_result,
    output logic [4:0]      o_riscv_mulctl_rdaddr,
    output logic            o_riscv_mulctl_timeout,
    output logic [XLEN-1:0] o_riscv_mulctl_mul_rs1data,
    output logic [XLEN-1:0] o_riscv_mulctl_mul_rs2data,
    output logic [3:0]      o_riscv_mulctl_mul_mulctrl,
    input  logic [XLEN-1:0] i_riscv_mulctl_mul_product,
    input  logic            i_riscv_mulctl_mul_valid
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StGap} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] wdog_q;
    logic             req_mul;
    logic             accept;
    logic             wdog_expired;
    logic             reuse_hit;

    assign req_mul      = i_riscv_mulctl_req_valid & i_riscv_mulctl_mulctrl[3];
    assign accept       = req_mul & ~i_riscv_mulctl_flush & ~o_riscv_mulctl_result_valid;
    assign wdog_expired = (wdog_q == CNT_LAST);

    assign o_riscv_mulctl_stall = req_mul & ((state_q != StIdle) | o_riscv_mulctl_result_valid)
                                  & ~i_riscv_mulctl_flush;

`ifdef RISCV_MUL_CTRL_REUSE_EN
    logic            tag_valid_q;
    logic [3:0]      tag_op_q;
    logic [XLEN-1:0] tag_rs1_q;
    logic [XLEN-1:0] tag_rs2_q;
    logic [XLEN-1:0] tag_prod_q;

    assign reuse_hit = tag_valid_q && (tag_op_q == i_riscv_mulctl_mulctrl)
                       && (tag_rs1_q == i_riscv_mulctl_rs1data)
                       && (tag_rs2_q == i_riscv_mulctl_rs2data);
`else
    assign reuse_hit = 1'b0;
`endif

    always_ff @(posedge i_riscv_mul_clk or posedge i_riscv_mul_rst) begin
        if (i_riscv_mul_rst) begin
            state_q                     <= StIdle;
            wdog_q                      <= '0;
            o_riscv_mulctl_result_valid <= 1'b0;
            o_riscv_mulctl_result       <= '0;
            o_riscv_mulctl_rdaddr       <= '0;
            o_riscv_mulctl_timeout      <= 1'b0;
            o_riscv_mulctl_mul_rs1data  <= '0;
            o_riscv_mulctl_mul_rs2data  <= '0;
            o_riscv_mulctl_mul_mulctrl  <= '0;
`ifdef RISCV_MUL_CTRL_REUSE_EN
            tag_valid_q                 <= 1'b0;
            tag_op_q                    <= '0;
            tag_rs1_q                   <= '0;
            tag_rs2_q                   <= '0;
            tag_prod_q                  <= '0;
`endif
        end else begin
            // Flush and ack both retire a held result; a flush needs nothing more.
            if (o_riscv_mulctl_result_valid && (i_riscv_mulctl_flush || i_riscv_mulctl_ack)) begin
                o_riscv_mulctl_result_valid <= 1'b0;
            end
`ifdef RISCV_MUL_CTRL_REUSE_EN
            if (i_riscv_mulctl_flush) begin
                tag_valid_q <= 1'b0;
            end
`endif
            unique case (state_q)
                StIdle: begin
                    if (accept && reuse_hit) begin
`ifdef RISCV_MUL_CTRL_REUSE_EN
                        o_riscv_mulctl_result_valid <= 1'b1;
                        o_riscv_mulctl_result       <= tag_prod_q;
`endif
                        o_riscv_mulctl_rdaddr       <= i_riscv_mulctl_rdaddr;
                    end else if (accept) begin
                        o_riscv_mulctl_mul_rs1data <= i_riscv_mulctl_rs1data;
                        o_riscv_mulctl_mul_rs2data <= i_riscv_mulctl_rs2data;
                        o_riscv_mulctl_mul_mulctrl <= i_riscv_mulctl_mulctrl;
                        o_riscv_mulctl_rdaddr      <= i_riscv_mulctl_rdaddr;
                        wdog_q                     <= '0;
                        state_q                    <= StRun;
                    end
                end
                StRun: begin
                    if (i_riscv_mulctl_mul_valid) begin
                        o_riscv_mulctl_mul_mulctrl <= 4'b0000;
                        state_q                    <= StGap;
                        if (!i_riscv_mulctl_flush) begin
                            o_riscv_mulctl_result       <= i_riscv_mulctl_mul_product;
                            o_riscv_mulctl_result_valid <= 1'b1;
`ifdef RISCV_MUL_CTRL_REUSE_EN
                            tag_valid_q <= 1'b1;
                            tag_op_q    <= o_riscv_mulctl_mul_mulctrl;
                            tag_rs1_q   <= o_riscv_mulctl_mul_rs1data;
                            tag_rs2_q   <= o_riscv_mulctl_mul_rs2data;
                            tag_prod_q  <= i_riscv_mulctl_mul_product;
`endif
                        end
                    end else if (wdog_expired) begin
                        o_riscv_mulctl_timeout     <= 1'b1;
                        o_riscv_mulctl_mul_mulctrl <= 4'b0000;
                        state_q                    <= StGap;
`ifdef RISCV_MUL_CTRL_REUSE_EN
                        tag_valid_q                <= 1'b0;
`endif
                    end else begin
                        wdog_q <= wdog_q + CNT_W'(1);
                        if (i_riscv_mulctl_flush) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    // The multiplier cannot abort: keep the op driven and discard its product.
                    if (i_riscv_mulctl_mul_valid) begin
                        o_riscv_mulctl_mul_mulctrl <= 4'b0000;
                        state_q                    <= StGap;
                    end else if (wdog_expired) begin
                        o_riscv_mulctl_timeout     <= 1'b1;
                        o_riscv_mulctl_mul_mulctrl <= 4'b0000;
                        state_q                    <= StGap;
                    end else begin
                        wdog_q <= wdog_q + CNT_W'(1);
                    end
                end
                StGap: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mul_ctrl.sv
// Directed bench for riscv_mul_ctrl with a behavioural stub multiplier of programmable latency.
module tb_riscv_mul_ctrl;

    localparam int unsigned XLEN = 64;

    logic            clk;
    logic            rst;
    logic            req_valid;
    logic [3:0]      mulctrl;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rd;
    logic            flush;
    logic            ack;
    logic            stall;
    logic            res_valid;
    logic [XLEN-1:0] result;
    logic [4:0]      res_rd;
    logic            timeout;
    logic [XLEN-1:0] mul_rs1;
    logic [XLEN-1:0] mul_rs2;
    logic [3:0]      mul_mulctrl;
    logic [XLEN-1:0] mul_product;
    logic            mul_valid;

    int n_checks   = 0;
    int n_failures = 0;
    bit hold_ok;
    int n_cyc;

    // Stub multiplier controls
    bit   stub_dead;
    int   mul_lat;
    logic stub_busy;
    logic stub_done;
    int   stub_cnt;

    riscv_mul_ctrl #(
        .TIMEOUT (96),
        .XLEN    (XLEN)
    ) dut (
        .i_riscv_mul_clk             (clk),
        .i_riscv_mul_rst             (rst),
        .i_riscv_mulctl_req_valid    (req_valid),
        .i_riscv_mulctl_mulctrl      (mulctrl),
        .i_riscv_mulctl_rs1data      (rs1),
        .i_riscv_mulctl_rs2data      (rs2),
        .i_riscv_mulctl_rdaddr       (rd),
        .i_riscv_mulctl_flush        (flush),
        .i_riscv_mulctl_ack          (ack),
        .o_riscv_mulctl_stall        (stall),
        .o_riscv_mulctl_result_valid (res_valid),
        .o_riscv_mulctl_result       (result),
        .o_riscv_mulctl_rdaddr       (res_rd),
        .o_riscv_mulctl_timeout      (timeout),
        .o_riscv_mulctl_mul_rs1data  (mul_rs1),
        .o_riscv_mulctl_mul_rs2data  (mul_rs2),
        .o_riscv_mulctl_mul_mulctrl  (mul_mulctrl),
        .i_riscv_mulctl_mul_product  (mul_product),
        .i_riscv_mulctl_mul_valid    (mul_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [127:0] p;
        logic [31:0]  w;
        case (op)
            4'b1100: begin p = {64'd0, a} * {64'd0, b};             return p[63:0];   end
            4'b1101: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            4'b1110: begin p = {64'd0, a} * {64'd0, b};             return p[127:64]; end
            4'b1111: begin p = {{64{a[63]}}, a} * {64'd0, b};       return p[127:64]; end
            4'b1000: begin w = a[31:0] * b[31:0]; return {{32{w[31]}}, w};             end
            default: return 64'd0;
        endcase
    endfunction

    // Starts on mulctrl[3], pulses valid after mul_lat cycles, rearms once mulctrl drops.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_busy   <= 1'b0;
            stub_done   <= 1'b0;
            stub_cnt    <= 0;
            mul_valid   <= 1'b0;
            mul_product <= '0;
        end else begin
            mul_valid <= 1'b0;
            if (stub_done) begin
                if (!mul_mulctrl[3]) stub_done <= 1'b0;
            end else if (!stub_busy) begin
                if (mul_mulctrl[3] && !stub_dead) begin
                    stub_busy <= 1'b1;
                    stub_cnt  <= mul_lat;
                end
            end else if (stub_cnt == 1) begin
                stub_busy   <= 1'b0;
                stub_done   <= 1'b1;
                mul_valid   <= 1'b1;
                mul_product <= ref_mul(mul_mulctrl, mul_rs1, mul_rs2);
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive_req(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                             input logic [4:0] dst);
        req_valid = 1'b1;
        mulctrl   = op;
        rs1       = a;
        rs2       = b;
        rd        = dst;
    endtask

    task automatic wait_rv(input string tag);
        for (int i = 0; i < 200 && !res_valid; i++) cyc();
        check_eq(tag, 64'(res_valid), 64'd1);
    endtask

    task automatic ack_pulse(input string tag);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        check_eq(tag, 64'(res_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit got=running exp=finished");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; mulctrl = '0; rs1 = '0; rs2 = '0; rd = '0;
        flush = 1'b0; ack = 1'b0; stub_dead = 1'b0; mul_lat = 8;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        check_eq("rst_result_valid", 64'(res_valid), 64'd0);
        check_eq("rst_result", result, 64'd0);
        check_eq("rst_rdaddr", 64'(res_rd), 64'd0);
        check_eq("rst_timeout", 64'(timeout), 64'd0);
        check_eq("rst_mulctrl", 64'(mul_mulctrl), 64'd0);
        check_eq("rst_mul_rs1", mul_rs1, 64'd0);
        check_eq("rst_stall", 64'(stall), 64'd0);

        // Non-multiply op must be ignored
        drive_req(4'b0100, 64'd5, 64'd6, 5'd1);
        cyc();
        check_eq("nonmul_ignored", 64'(mul_mulctrl), 64'd0);
        req_valid = 1'b0;
        cyc();

        // MUL 7 * -3 with ack held high
        drive_req(4'b1100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5);
        ack = 1'b1;
        #1 check_eq("t1_stall_idle", 64'(stall), 64'd0);
        cyc();
        check_eq("t1_op_start", 64'(mul_mulctrl), 64'hC);
        check_eq("t1_rs2_latched", mul_rs2, 64'hFFFF_FFFF_FFFF_FFFD);
        rs1 = 64'hDEAD;
        rs2 = 64'd0;
        hold_ok = 1'b1;
        for (int i = 0; i < 50 && !res_valid; i++) begin
            if (mul_mulctrl != 4'b1100 || mul_rs1 != 64'd7 || !stall) hold_ok = 1'b0;
            cyc();
        end
        check_eq("t1_hold_and_stall", 64'(hold_ok), 64'd1);
        check_eq("t1_result_valid", 64'(res_valid), 64'd1);
        check_eq("t1_result", result, 64'hFFFF_FFFF_FFFF_FFEB);
        check_eq("t1_rdaddr", 64'(res_rd), 64'd5);
        check_eq("t1_stall_at_rv", 64'(stall), 64'd1);
        check_eq("t1_gap_mulctrl", 64'(mul_mulctrl), 64'd0);
        req_valid = 1'b0;
        cyc();
        check_eq("t1_ack_clear", 64'(res_valid), 64'd0);
        ack = 1'b0;

        // MULHU all-ones, ack delayed while a second request waits
        drive_req(4'b1110, '1, '1, 5'd9);
        cyc();
        req_valid = 1'b0;
        wait_rv("t2_wait");
        check_eq("t2_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
        drive_req(4'b1100, 64'd2, 64'd3, 5'd3);
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (!res_valid || result != 64'hFFFF_FFFF_FFFF_FFFE || res_rd != 5'd9 || !stall
                || mul_mulctrl != 4'b0000) hold_ok = 1'b0;
        end
        check_eq("t2_hold_stall", 64'(hold_ok), 64'd1);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        check_eq("t2_ack_clear", 64'(res_valid), 64'd0);
        check_eq("t2_stall_released", 64'(stall), 64'd0);
        cyc();
        check_eq("t2_second_start", 64'(mul_mulctrl), 64'hC);
        req_valid = 1'b0;
        wait_rv("t2_second_wait");
        check_eq("t2_second_result", result, 64'd6);
        check_eq("t2_second_rd", 64'(res_rd), 64'd3);
        ack_pulse("t2_second_ack");

        // Flush 10 cycles into MULH: drain, no result
        mul_lat = 20;
        drive_req(4'b1101, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 5'd11);
        cyc();
        req_valid = 1'b0;
        repeat (10) cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        hold_ok = 1'b1;
        for (int i = 0; i < 100 && !mul_valid; i++) begin
            if (mul_mulctrl != 4'b1101 || res_valid) hold_ok = 1'b0;
            cyc();
        end
        check_eq("t3_drain_hold", 64'(hold_ok), 64'd1);
        check_eq("t3_drain_done", 64'(mul_valid), 64'd1);
        mul_lat = 8;
        cyc();
        check_eq("t3_gap_mulctrl", 64'(mul_mulctrl), 64'd0);
        check_eq("t3_no_result", 64'(res_valid), 64'd0);
        drive_req(4'b1111, '1, 64'd2, 5'd2);
        #1 check_eq("t3_stall_in_gap", 64'(stall), 64'd1);
        cyc();
        check_eq("t3_stall_after_gap", 64'(stall), 64'd0);
        cyc();
        check_eq("t3_next_start", 64'(mul_mulctrl), 64'hF);
        req_valid = 1'b0;
        wait_rv("t3_next_wait");
        check_eq("t3_mulhsu_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("t3_mulhsu_rd", 64'(res_rd), 64'd2);
        ack_pulse("t3_ack");

        // Flush coincident with mul_valid
        drive_req(4'b1100, 64'd3, 64'd4, 5'd12);
        cyc();
        req_valid = 1'b0;
        for (int i = 0; i < 100 && !mul_valid; i++) cyc();
        check_eq("t4_valid_seen", 64'(mul_valid), 64'd1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check_eq("t4_discard", 64'(res_valid), 64'd0);
        check_eq("t4_gap_mulctrl", 64'(mul_mulctrl), 64'd0);
        cyc();
        check_eq("t4_still_none", 64'(res_valid), 64'd0);

        // Dead multiplier: watchdog fires 96 cycles after RUN entry
        stub_dead = 1'b1;
        drive_req(4'b1100, 64'd1, 64'd1, 5'd8);
        cyc();
        req_valid = 1'b0;
        n_cyc = 0;
        while (!timeout && n_cyc < 200) begin
            cyc();
            n_cyc++;
        end
        check_eq("t5_timeout_cycles", 64'(n_cyc), 64'd96);
        check_eq("t5_gap_mulctrl", 64'(mul_mulctrl), 64'd0);
        check_eq("t5_no_result", 64'(res_valid), 64'd0);
        stub_dead = 1'b0;
        drive_req(4'b1100, 64'd5, 64'd5, 5'd4);
        #1 check_eq("t5_stall_in_gap", 64'(stall), 64'd1);
        cyc();
        check_eq("t5_idle_again", 64'(stall), 64'd0);
        cyc();
        check_eq("t5_restart", 64'(mul_mulctrl), 64'hC);
        req_valid = 1'b0;
        wait_rv("t5_wait");
        check_eq("t5_result", result, 64'd25);
        ack_pulse("t5_ack");
        check_eq("t5_timeout_sticky", 64'(timeout), 64'd1);

        // MULW 0x8000_0000 * 2, issued twice
        drive_req(4'b1000, 64'h8000_0000, 64'd2, 5'd7);
        cyc();
        req_valid = 1'b0;
        wait_rv("t6_first_wait");
        check_eq("t6_first_result", result, 64'd0);
        ack_pulse("t6_first_ack");
        drive_req(4'b1000, 64'h8000_0000, 64'd2, 5'd7);
        cyc();
`ifdef RISCV_MUL_CTRL_REUSE_EN
        check_eq("t6_reuse_valid", 64'(res_valid), 64'd1);
        check_eq("t6_reuse_no_start", 64'(mul_mulctrl), 64'd0);
        req_valid = 1'b0;
`else
        check_eq("t6_rerun_start", 64'(mul_mulctrl), 64'h8);
        req_valid = 1'b0;
        wait_rv("t6_rerun_wait");
`endif
        check_eq("t6_second_result", result, 64'd0);
        check_eq("t6_second_rd", 64'(res_rd), 64'd7);
        ack_pulse("t6_second_ack");

        // Asynchronous reset in the middle of RUN
        drive_req(4'b1100, 64'd7, 64'd7, 5'd13);
        cyc();
        req_valid = 1'b0;
        repeat (3) cyc();
        #2 rst = 1'b1;
        #1;
        check_eq("t7_mulctrl", 64'(mul_mulctrl), 64'd0);
        check_eq("t7_mul_rs1", mul_rs1, 64'd0);
        check_eq("t7_result", result, 64'd0);
        check_eq("t7_rdaddr", 64'(res_rd), 64'd0);
        check_eq("t7_timeout", 64'(timeout), 64'd0);
        check_eq("t7_result_valid", 64'(res_valid), 64'd0);
        cyc();
        rst = 1'b0;
        cyc();
        check_eq("t7_idle_after", 64'(mul_mulctrl), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
